const_sel_encoder: RTL and testbench



---
 rtl/const_sel_encoder.sv | 166 ++++++++++++++++
 tb/tb_const_sel_encoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/const_sel_encoder.sv
// Constant-select encoder: finds the 4-bit mux select code that reproduces a 17-bit value.
// Define CONST_SEL_FAST_EN for a single-cycle parallel compare instead of the sequential scan.
module const_sel_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sel,
  output logic             out_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [3:0] LAST_CODE = 4'd10;

  // Mirrors the output mux decode, including code 5 reading back as 4 and value 5 absent.
  function automatic logic [16:0] table_val(input logic [3:0] code);
    case (code)
      4'd1:    table_val = 17'd0;
      4'd2:    table_val = 17'd1;
      4'd3:    table_val = 17'd2;
      4'd4:    table_val = 17'd3;
      4'd5:    table_val = 17'd4;
      4'd6:    table_val = 17'd6;
      4'd7:    table_val = 17'd7;
      4'd8:    table_val = 17'd8;
      4'd9:    table_val = 17'd9;
      4'd10:   table_val = 17'd15;
      default: table_val = 17'd0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [16:0]      cap_q, cap_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_sel_q, out_sel_d;
  logic             out_hit_q, out_hit_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

`ifdef CONST_SEL_FAST_EN
  logic [3:0] fast_sel;
  logic       fast_hit;

  // Walk from the highest code down so the lowest matching code is the one left standing.
  always_comb begin
    fast_sel = 4'd0;
    fast_hit = 1'b0;
    for (int c = 10; c >= 1; c--) begin
      if (cap_q == table_val(4'(c))) begin
        fast_sel = 4'(c);
        fast_hit = 1'b1;
      end
    end
  end
`else
  logic [3:0] idx_q, idx_d;
`endif

  // NOTE: every _d starts from its _q so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_hit_d   = out_hit_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
`ifndef CONST_SEL_FAST_EN
    idx_d       = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          cap_d      = in_data;
          in_ready_d = 1'b0;
          state_d    = SCAN;
`ifndef CONST_SEL_FAST_EN
          idx_d      = 4'd1;
`endif
        end
      end
      SCAN: begin
`ifdef CONST_SEL_FAST_EN
        out_sel_d   = fast_sel;
        out_hit_d   = fast_hit;
        out_valid_d = 1'b1;
        state_d     = HOLD;
`else
        if (cap_q == table_val(idx_q)) begin
          out_sel_d   = idx_q;
          out_hit_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (idx_q == LAST_CODE) begin
          out_sel_d   = 4'd0;
          out_hit_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          idx_d = idx_q + 4'd1;
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
          if (out_hit_q) begin
            if (hit_q != {CNT_W{1'b1}}) hit_d = hit_q + 1'b1;
          end else begin
            if (miss_q != {CNT_W{1'b1}}) miss_d = miss_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_hit_q   <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
`ifndef CONST_SEL_FAST_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_hit_q   <= out_hit_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
`ifndef CONST_SEL_FAST_EN
      idx_q       <= idx_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sel    = out_sel_q;
  assign out_hit    = out_hit_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_const_sel_encoder.sv
// Directed bench for const_sel_encoder: hits, misses, quirks, stalls, mid-scan reset, saturation.
module tb_const_sel_encoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [16:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_sel;
  logic             out_hit;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_hc = '0;
  logic [CNT_W-1:0] exp_mc = '0;

  const_sel_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sel    (out_sel),
    .out_hit    (out_hit),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction; stall = cycles the consumer withholds out_ready in HOLD.
  task automatic txn(input logic [16:0] d, input logic [3:0] sel, input logic hit,
                     input int stall);
    int lat;
    int exp_lat;
`ifdef CONST_SEL_FAST_EN
    exp_lat = 1;
`else
    exp_lat = hit ? int'(sel) : 10;
`endif
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, exp_lat);
    check("out_sel", out_sel, sel);
    check("out_hit", out_hit, hit);
    check("busy_in_ready", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_sel", out_sel, sel);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (hit) begin
      if (exp_hc != {CNT_W{1'b1}}) exp_hc = exp_hc + 1'b1;
    end else begin
      if (exp_mc != {CNT_W{1'b1}}) exp_mc = exp_mc + 1'b1;
    end
    check("rel_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);
    check("rel_sel_kept", out_sel, sel);
    check("hit_count", hit_count, exp_hc);
    check("miss_count", miss_count, exp_mc);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_hit", out_hit, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    @(negedge clk);
    reset = 1'b0;

    txn(17'h00000, 4'd1,  1'b1, 0);
    txn(17'd15,    4'd10, 1'b1, 0);
    txn(17'd5,     4'd0,  1'b0, 0);
    txn(17'h10000, 4'd0,  1'b0, 0);
    check("two_misses", miss_count, 2);
    txn(17'd6,     4'd6,  1'b1, 5);
    txn(17'd4,     4'd5,  1'b1, 0);
    txn(17'd3,     4'd4,  1'b1, 0);
    txn(17'd8,     4'd8,  1'b1, 1);
    txn(17'h1000F, 4'd0,  1'b0, 0);

    // Reset during the scan of 9: pending result is discarded and counters clear.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 17'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_hits", hit_count, 0);
    check("mid_rst_misses", miss_count, 0);
    exp_hc = '0;
    exp_mc = '0;
    @(negedge clk);
    reset = 1'b0;
    txn(17'd2, 4'd3, 1'b1, 0);

    for (int n = 0; n < 256; n++) txn(17'd0, 4'd1, 1'b1, 0);
    check("hit_saturated", hit_count, 255);
    check("miss_after_sat", miss_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
